// File: rtl/instr_fetch.sv
// Instruction fetch: two byte reads per 16-bit big-endian instruction, presented over valid/ready.
// Optional FETCH_ALIGN_CHK_EN: a misaligned redirect faults instead of being silently aligned.
module instr_fetch #(
  parameter int                ADDR_W   = 11,
  parameter int                MEM_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 nrst,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [MEM_W-1:0]     mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*MEM_W-1:0]   out_instr,
  output logic [ADDR_W-1:0]    out_pc,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 fault
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    CAPT,
    VALID
`ifdef FETCH_ALIGN_CHK_EN
    , FAULT
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    pc;
  logic [MEM_W-1:0]     hi;
  logic [ADDR_W-1:0]    tgt;
  logic                 misalign;
  logic                 take;

`ifdef FETCH_ALIGN_CHK_EN
  assign tgt      = redirect_pc;
  assign misalign = redirect_pc[0];
`else
  assign tgt      = redirect_pc & ~ONE;
  assign misalign = 1'b0;
  assign fault    = 1'b0;
`endif

  assign take = out_valid & out_ready;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE:   state_nxt = REQ_HI;
      REQ_HI: begin
        mem_rd    = 1'b1;
        mem_addr  = pc;
        state_nxt = REQ_LO;
      end
      REQ_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = pc + ONE;
        state_nxt = CAPT;
      end
      CAPT:   state_nxt = VALID;
      VALID:  if (take) state_nxt = REQ_HI;
`ifdef FETCH_ALIGN_CHK_EN
      FAULT:  state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase
`ifdef FETCH_ALIGN_CHK_EN
    if (redirect) state_nxt = misalign ? FAULT : REQ_HI;
`else
    if (redirect) state_nxt = REQ_HI;
`endif
  end

  // A redirect overrides every datapath update, so in-flight bytes never reach out_valid.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      pc        <= RESET_PC;
      hi        <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
`ifdef FETCH_ALIGN_CHK_EN
      fault     <= 1'b0;
`endif
    end else if (redirect) begin
      out_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      if (misalign) begin
        fault <= 1'b1;
      end else begin
        fault <= 1'b0;
        pc    <= tgt;
      end
`else
      pc        <= tgt;
`endif
    end else begin
      case (state)
        REQ_LO: hi <= mem_rdata;
        CAPT: begin
          out_instr <= {hi, mem_rdata};
          out_pc    <= pc;
          out_valid <= 1'b1;
        end
        VALID: begin
          if (take) begin
            out_valid <= 1'b0;
            pc        <= pc + TWO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
